// File: rtl/input_conditioner_pkg.sv
// Shared constants and types for the input conditioner.
// Optional build macro: SW_CHANGE_IRQ_EN (switch changes also raise irq).
package input_cond_pkg;

  // 10 ms of stable input at 32 MHz
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 320000;

  // Counter width able to hold 0..cycles-1; never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  localparam int unsigned CNT_W_DEF = cnt_width(DEBOUNCE_CYCLES_DEF);

  // Interrupt request state: irq output equals the state bit
  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } irq_state_e;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// Single-bit synchroniser plus debounce filter.
// The stable output only follows the synchronised input after it has
// differed for DEBOUNCE_CYCLES consecutive cycles.
module debounce_bit
  import input_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned       CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   s;

  assign s    = sync_q[SYNC_STAGES-1];
  assign dout = stable_q;

  // Shift the raw input through the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Count consecutive mismatch cycles; any return to the stable value restarts
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (s != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = s;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner: debounces NSW switches and the interrupt button,
// turns debounced button presses into a sticky irq held until acked, and
// counts presses lost while irq is already pending.
// Optional build macro: SW_CHANGE_IRQ_EN -- any sw_clean change also
// counts as an irq event.
module input_conditioner
  import input_cond_pkg::*;
#(
  parameter int unsigned NSW             = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned MISS_W          = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSW-1:0]    sw_raw,
  input  logic              btn_raw,
  input  logic              irq_ack,
  output logic [NSW-1:0]    sw_clean,
  output logic              btn_clean,
  output logic              irq,
  output logic [MISS_W-1:0] miss_cnt
);

  logic [NSW:0]        raw_all;
  logic [NSW:0]        clean_all;
  logic                btn_prev_q, btn_prev_d;
  logic                rise_btn;
  logic                irq_event;
  irq_state_e          state_q, state_d;
  logic [MISS_W-1:0]   miss_q, miss_d;

  // Button occupies the top bit so all inputs share one filter array
  assign raw_all = {btn_raw, sw_raw};

  for (genvar i = 0; i <= NSW; i++) begin : g_db
    debounce_bit #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (raw_all[i]),
      .dout (clean_all[i])
    );
  end

  assign sw_clean  = clean_all[NSW-1:0];
  assign btn_clean = clean_all[NSW];

  // Previous debounced button level for rising-edge detection
  always_comb begin
    btn_prev_d = btn_clean;
  end

  assign rise_btn = btn_clean & ~btn_prev_q;

`ifdef SW_CHANGE_IRQ_EN
  logic [NSW-1:0] sw_prev_q, sw_prev_d;

  // Previous debounced switch word for change detection
  always_comb begin
    sw_prev_d = sw_clean;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sw_prev_q <= '0;
    else        sw_prev_q <= sw_prev_d;
  end

  // Simultaneous button and switch events collapse into one
  assign irq_event = rise_btn | (sw_clean != sw_prev_q);
`else
  assign irq_event = rise_btn;
`endif

  // IRQ FSM and saturating missed-event counter; a new event beats a same-cycle ack
  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    unique case (state_q)
      IDLE: begin
        if (irq_event) state_d = PEND;
      end
      PEND: begin
        if (irq_event) begin
          if (!irq_ack && (miss_q != '1)) miss_d = miss_q + 1'b1;
        end else if (irq_ack) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_prev_q <= 1'b0;
      state_q    <= IDLE;
      miss_q     <= '0;
    end else begin
      btn_prev_q <= btn_prev_d;
      state_q    <= state_d;
      miss_q     <= miss_d;
    end
  end

  assign irq      = (state_q == PEND);
  assign miss_cnt = miss_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_input_conditioner;

  logic       clk;
  logic       rst_n;
  logic [7:0] sw_raw;
  logic       btn_raw;
  logic       irq_ack;
  logic [7:0] sw_clean;
  logic       btn_clean;
  logic       irq;
  logic [3:0] miss_cnt;

  int checks;
  int errors;

  input_conditioner #(
    .NSW             (8),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .MISS_W          (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_raw   (sw_raw),
    .btn_raw  (btn_raw),
    .irq_ack  (irq_ack),
    .sw_clean (sw_clean),
    .btn_clean(btn_clean),
    .irq      (irq),
    .miss_cnt (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One full press and release, each phase long enough to be accepted
  task automatic press();
    btn_raw = 1'b1;
    tick(6);
    btn_raw = 1'b0;
    tick(6);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sw_raw = '0; btn_raw = 1'b0; irq_ack = 1'b0;
    tick(3);
    checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL reset_sw got %h want 00", sw_clean); end
    checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL reset_btn got %b want 0", btn_clean); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", irq); end
    checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL reset_miss got %0d want 0", miss_cnt); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_switch();
    sw_raw = 8'hA5;
    tick(5);
    checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL sw_early got %h want 00", sw_clean); end
    tick(1);
    checks++; if (sw_clean !== 8'hA5) begin errors++; $display("FAIL sw_latency got %h want a5", sw_clean); end
    tick(4);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL sw_no_irq got %b want 0", irq); end
  endtask

  task automatic test_bounce();
    int rises;
    logic prev;
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1; tick(1);
    btn_raw = 1'b0; tick(1);
    btn_raw = 1'b1;
    tick(5);
    checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL bounce_early got %b want 0", btn_clean); end
    tick(1);
    checks++; if (btn_clean !== 1'b1) begin errors++; $display("FAIL bounce_latency got %b want 1", btn_clean); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL bounce_irq_early got %b want 0", irq); end
    rises = 0;
    prev  = irq;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (irq && !prev) rises++;
      prev = irq;
    end
    checks++; if (rises != 1) begin errors++; $display("FAIL bounce_irq_count got %0d want 1", rises); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL bounce_irq_held got %b want 1", irq); end
    checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL bounce_miss got %0d want 0", miss_cnt); end
  endtask

  task automatic test_ack();
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_clear got %b want 0", irq); end
    tick(1);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    tick(1);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ack_idle got %b want 0", irq); end
    btn_raw = 1'b0;
    tick(8);
    checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL release_btn got %b want 0", btn_clean); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL release_irq got %b want 0", irq); end
    checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL ack_miss got %0d want 0", miss_cnt); end
  endtask

  task automatic test_miss_saturate();
    press();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL miss_first_irq got %b want 1", irq); end
    checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL miss_first got %0d want 0", miss_cnt); end
    press();
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL miss_second_irq got %b want 1", irq); end
    checks++; if (miss_cnt !== 4'd1) begin errors++; $display("FAIL miss_second got %0d want 1", miss_cnt); end
    for (int k = 0; k < 13; k++) press();
    checks++; if (miss_cnt !== 4'd14) begin errors++; $display("FAIL miss_14 got %0d want 14", miss_cnt); end
    press();
    checks++; if (miss_cnt !== 4'd15) begin errors++; $display("FAIL miss_15 got %0d want 15", miss_cnt); end
    for (int k = 0; k < 6; k++) press();
    checks++; if (miss_cnt !== 4'd15) begin errors++; $display("FAIL miss_sat got %0d want 15", miss_cnt); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL miss_sat_irq got %b want 1", irq); end
  endtask

  task automatic test_async_reset();
    btn_raw = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL areset_irq got %b want 0", irq); end
    checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL areset_miss got %0d want 0", miss_cnt); end
    checks++; if (sw_clean !== 8'h00) begin errors++; $display("FAIL areset_sw got %h want 00", sw_clean); end
    checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL areset_btn got %b want 0", btn_clean); end
    tick(2);
    rst_n = 1'b1;
    tick(5);
    checks++; if (btn_clean !== 1'b0) begin errors++; $display("FAIL requal_early got %b want 0", btn_clean); end
    tick(1);
    checks++; if (btn_clean !== 1'b1) begin errors++; $display("FAIL requal_btn got %b want 1", btn_clean); end
    checks++; if (sw_clean !== 8'hA5) begin errors++; $display("FAIL requal_sw got %h want a5", sw_clean); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL requal_irq got %b want 1", irq); end
  endtask

  task automatic test_ack_and_rise();
    btn_raw = 1'b0;
    tick(6);
    btn_raw = 1'b1;
    tick(6);
    irq_ack = 1'b1;
    tick(1);
    irq_ack = 1'b0;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL ackrise_irq got %b want 1", irq); end
    checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL ackrise_miss got %0d want 0", miss_cnt); end
    tick(2);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL ackrise_clear got %b want 0", irq); end
    checks++; if (miss_cnt !== 4'd0) begin errors++; $display("FAIL ackrise_miss_after got %0d want 0", miss_cnt); end
  endtask

`ifdef SW_CHANGE_IRQ_EN
  task automatic test_sw_irq();
    sw_raw = 8'h00;
    tick(8);
    irq_ack = 1'b1; tick(1); irq_ack = 1'b0;
    tick(2);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL swirq_idle got %b want 0", irq); end
    sw_raw = 8'h01;
    tick(6);
    checks++; if (sw_clean !== 8'h01) begin errors++; $display("FAIL swirq_sw got %h want 01", sw_clean); end
    tick(1);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL swirq_irq got %b want 1", irq); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_switch();
    test_bounce();
    test_ack();
    test_miss_saturate();
    test_async_reset();
    test_ack_and_rise();
`ifdef SW_CHANGE_IRQ_EN
    test_sw_irq();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
